// File: rtl/scct_irq_master.sv
// scct interrupt service initiator: enables IE at init, then on irq reads IS, acks channels lowest-first, queues {ch, ts} events.
// Latency: irq registered (1 cycle), IS readback after RD_LAT, one event per PUSH/ACK pair (2 cycles per channel).
// Backpressure: a full event FIFO parks the FSM in PUSH without acking, so pending channels stay pending in scct.

`ifndef SCCT_N_CHANNELS
`define SCCT_N_CHANNELS 8
`endif
`ifndef SCCT_CH_IS
`define SCCT_CH_IS 5'h04
`endif
`ifndef SCCT_CH_IE
`define SCCT_CH_IE 5'h05
`endif

// Generic first-word fall-through FIFO.
// Latency: write visible at rd_dat the cycle after wr_vld.
// Backpressure: caller must not push when full unless popping in the same cycle.
module scct_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_ptr_d = wr_ptr_q + PW'(wr_vld);
        rd_ptr_d = rd_ptr_q + PW'(rd_rdy);
        rd_dat   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
endmodule

module scct_irq_master #(
    parameter int              N_CH       = `SCCT_N_CHANNELS,
    parameter int              CH_W       = 3,
    parameter int              TS_W       = 16,
    parameter int              FIFO_DEPTH = 4,
    parameter int              RD_LAT     = 1,
    parameter logic [4:0]      ADDR_IS    = `SCCT_CH_IS,
    parameter logic [4:0]      ADDR_IE    = `SCCT_CH_IE,
    parameter logic [N_CH-1:0] IE_MASK    = {N_CH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [4:0]           address,
    output logic                 read,
    input  logic [31:0]          readdata,
    output logic [31:0]          writedata,
    output logic                 write,
    input  logic                 irq,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [CH_W+TS_W-1:0] evt_data,
    output logic                 busy
);
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_IS, S_WAIT, S_DECIDE, S_PUSH, S_ACK
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [TS_W-1:0] ts;
    } evt_t;

    localparam int               LAT_W   = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT);

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [N_CH-1:0]   is_q, is_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              irq_q;
    logic [4:0]        address_q, address_d;
    logic [31:0]       writedata_q, writedata_d;

    logic [CH_W-1:0]   ch;
    logic [N_CH-1:0]   ch_bit;
    logic              evt_push, evt_pop, fifo_full, fifo_empty;
    evt_t              evt_in, evt_out;
    logic              unused_rd;

    // Bits of readdata at and above N_CH are deliberately dropped.
    assign unused_rd = ^readdata;

    // Lowest set bit of the latched status wins.
    always_comb begin
        ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (is_q[i]) ch = CH_W'(i);
        end
        ch_bit = N_CH'(1) << ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            lat_q       <= '0;
            is_q        <= '0;
            ts_q        <= '0;
            irq_q       <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            is_q        <= is_d;
            ts_q        <= ts_d;
            irq_q       <= irq;
            address_q   <= address_d;
            writedata_q <= writedata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        is_d    = is_q;
        ts_d    = ts_q + TS_W'(1);
        case (state_q)
            S_INIT:  state_d = S_IDLE;
            S_IDLE:  if (irq_q) state_d = S_RD_IS;
            S_RD_IS: begin
                state_d = S_WAIT;
                lat_d   = LAT_W'(1);
            end
            S_WAIT: begin
                if (lat_q == LAT_MAX) begin
                    is_d    = readdata[N_CH-1:0];
                    state_d = S_DECIDE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_DECIDE: state_d = (is_q == '0) ? S_IDLE : S_PUSH;
            S_PUSH:   if (evt_push) state_d = S_ACK;
            S_ACK: begin
                // Drain the latched status before re-reading for late arrivals.
                is_d    = is_q & ~ch_bit;
                state_d = (is_d != '0) ? S_PUSH : S_RD_IS;
            end
            default:  state_d = S_INIT;
        endcase
    end

    // Strobes are gated by rst so nothing reaches the bus while reset is held.
    always_comb begin
        read        = 1'b0;
        write       = 1'b0;
        address_d   = address_q;
        writedata_d = writedata_q;
        if (!rst) begin
            case (state_q)
                S_INIT: begin
                    write       = 1'b1;
                    address_d   = ADDR_IE;
                    writedata_d = 32'(IE_MASK);
                end
                S_RD_IS: begin
                    read      = 1'b1;
                    address_d = ADDR_IS;
                end
                S_ACK: begin
                    write       = 1'b1;
                    address_d   = ADDR_IS;
                    writedata_d = 32'b1 << ch;
                end
                default: ;
            endcase
        end
        address   = address_d;
        writedata = writedata_d;
        busy      = (state_q != S_IDLE);
        evt_valid = !fifo_empty;
        evt_pop   = evt_valid && evt_ready;
        evt_push  = !rst && (state_q == S_PUSH) && (!fifo_full || evt_pop);
        evt_in    = '{ch: ch, ts: ts_q};
        evt_data  = evt_out;
    end

    scct_evt_fifo #(
        .W     ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (evt_push),
        .wr_dat (evt_in),
        .rd_rdy (evt_pop),
        .rd_dat (evt_out),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );
endmodule
